md_unit: RTL and testbench

//  Parametrised multiply/divide unit with HI/LO registers for the EX stage of the P7 pipeline.
//  - Executes the MD ops flagged by the decoder: mult, multu, div, divu, mfhi, mflo, mthi, mtlo.
//  - Models multi-cycle latency with a busy counter. Drives the D-stage stall for MD ops.
//  - Runs an MD op only when it is valid and not flushed by an exception or interrupt.

---
 rtl/md_unit.sv | 146 ++++++++++++++
 tb/tb_md_unit.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers for the EX stage.
// Results are computed at start and held in pending registers until the busy counter expires.
module md_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       op_e,
  input  logic             valid_e,
  input  logic             flush,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op_d,
  output logic             busy,
  output logic             md_stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rdata
);

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMfhi  = 4'd5;
  localparam logic [3:0] OpMflo  = 4'd6;
  localparam logic [3:0] OpMthi  = 4'd7;
  localparam logic [3:0] OpMtlo  = 4'd8;

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  logic accept, start, op_d_md;

  // Arithmetic datapath
  logic [2*WIDTH-1:0]      prod_s, prod_u;
  logic signed [WIDTH-1:0] a_s, b_s, quot_s, rem_s;
  logic [WIDTH-1:0]        quot_u, rem_u;
  logic                    div_zero, div_ovf;
  logic [WIDTH-1:0]        res_hi, res_lo;

  // Sign-extending to 2*WIDTH makes the low 2*WIDTH bits of the product the signed result.
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign a_s    = $signed(a);
  assign b_s    = $signed(b);
  assign quot_s = a_s / b_s;
  assign rem_s  = a_s % b_s;
  assign quot_u = a / b;
  assign rem_u  = a % b;

  assign div_zero = (b == '0);
  assign div_ovf  = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    unique case (op_e)
      OpMult:  {res_hi, res_lo} = prod_s;
      OpMultu: {res_hi, res_lo} = prod_u;
      OpDiv: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = '1;
        end else if (div_ovf) begin
          res_hi = '0;
          res_lo = a;
        end else begin
          res_hi = rem_s;
          res_lo = quot_s;
        end
      end
      OpDivu: begin
        if (div_zero) begin
          res_hi = a;
          res_lo = '1;
        end else begin
          res_hi = rem_u;
          res_lo = quot_u;
        end
      end
      default: ;
    endcase
  end

  assign busy    = (count_q != '0);
  assign accept  = valid_e & ~flush & ~busy;
  assign start   = accept & (op_e >= OpMult) & (op_e <= OpDivu);
  assign op_d_md = (op_d >= OpMult) & (op_d <= OpMtlo);

  always_comb begin
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    if (busy) begin
      // A started op always runs to completion; flush does not touch the counter.
      count_d = count_q - 1'b1;
      if (count_q == CntW'(1)) begin
        hi_d = pend_hi_q;
        lo_d = pend_lo_q;
      end
    end else if (accept) begin
      if (start) begin
        pend_hi_d = res_hi;
        pend_lo_d = res_lo;
        count_d   = ((op_e == OpMult) || (op_e == OpMultu)) ? CntW'(MULT_CYCLES)
                                                            : CntW'(DIV_CYCLES);
      end else if (op_e == OpMthi) begin
        hi_d = a;
      end else if (op_e == OpMtlo) begin
        lo_d = a;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  assign hi       = hi_q;
  assign lo       = lo_q;
  assign md_stall = op_d_md & (busy | start);
  assign rdata    = (op_e == OpMfhi) ? hi_q : (op_e == OpMflo) ? lo_q : '0;

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: directed cases followed by randomized traffic
// compared against an arithmetic reference model.
module tb_md_unit;

  logic        clk;
  logic        rst_n;
  logic [3:0]  op_e, op_d;
  logic        valid_e, flush;
  logic [31:0] a, b;
  logic        busy, md_stall;
  logic [31:0] hi, lo, rdata;

  md_unit #(
    .WIDTH      (32),
    .MULT_CYCLES(5),
    .DIV_CYCLES (10)
  ) u_dut (
    .clk     (clk),
    .reset   (rst_n),
    .op_e    (op_e),
    .valid_e (valid_e),
    .flush   (flush),
    .a       (a),
    .b       (b),
    .op_d    (op_d),
    .busy    (busy),
    .md_stall(md_stall),
    .hi      (hi),
    .lo      (lo),
    .rdata   (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_hi, m_lo, m_ph, m_pl;
  int          m_left;

  // Last observed outputs from step()
  logic        obs_busy, obs_stall;
  logic [31:0] obs_rdata;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_md(input logic [3:0] op);
    return (op >= 4'd1) && (op <= 4'd8);
  endfunction

  task automatic model_edge(input logic [3:0] op, input logic v, input logic f,
                            input logic [31:0] av, input logic [31:0] bv);
    longint      sa, sb, ma, mb, q, r, p;
    logic [63:0] pu;
    if (m_left > 0) begin
      if (m_left == 1) begin
        m_hi = m_ph;
        m_lo = m_pl;
      end
      m_left--;
    end else if (v && !f) begin
      sa = longint'($signed(av));
      sb = longint'($signed(bv));
      case (op)
        4'd1: begin
          p = sa * sb;
          m_ph = 32'(p >>> 32);
          m_pl = 32'(p);
          m_left = 5;
        end
        4'd2: begin
          pu = 64'(av) * 64'(bv);
          m_ph = pu[63:32];
          m_pl = pu[31:0];
          m_left = 5;
        end
        4'd3: begin
          if (sb == 0) begin
            m_ph = av;
            m_pl = 32'hFFFF_FFFF;
          end else begin
            ma = (sa < 0) ? -sa : sa;
            mb = (sb < 0) ? -sb : sb;
            q = ma / mb;
            r = ma % mb;
            if ((sa < 0) != (sb < 0)) q = -q;
            if (sa < 0) r = -r;
            m_pl = 32'(q);
            m_ph = 32'(r);
          end
          m_left = 10;
        end
        4'd4: begin
          if (bv == 0) begin
            m_ph = av;
            m_pl = 32'hFFFF_FFFF;
          end else begin
            m_pl = av / bv;
            m_ph = av % bv;
          end
          m_left = 10;
        end
        4'd7: m_hi = av;
        4'd8: m_lo = av;
        default: ;
      endcase
    end
  endtask

  task automatic step(input logic [3:0] op, input logic v, input logic f,
                      input logic [31:0] av, input logic [31:0] bv, input logic [3:0] od);
    logic        e_busy, e_stall;
    logic [31:0] e_rdata;
    @(negedge clk);
    op_e = op; valid_e = v; flush = f; a = av; b = bv; op_d = od;
    #1;
    e_busy  = (m_left != 0);
    e_stall = is_md(od) && (e_busy || (v && !f && op >= 4'd1 && op <= 4'd4));
    e_rdata = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'h0;
    obs_busy = busy; obs_stall = md_stall; obs_rdata = rdata;
    chk("busy", {31'b0, busy}, {31'b0, e_busy});
    chk("md_stall", {31'b0, md_stall}, {31'b0, e_stall});
    chk("rdata", rdata, e_rdata);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    @(posedge clk);
    model_edge(op, v, f, av, bv);
  endtask

  task automatic idle(input logic [3:0] od);
    step(4'd0, 1'b0, 1'b0, 32'h0, 32'h0, od);
  endtask

  // Idle until busy drops; returns the number of busy and stalled cycles seen.
  task automatic wait_free(input logic [3:0] od, output int nbusy, output int nstall);
    nbusy = 0;
    nstall = 0;
    for (int i = 0; i < 40; i++) begin
      idle(od);
      if (obs_stall) nstall++;
      if (!obs_busy) break;
      nbusy++;
    end
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    op_e = 4'd0; valid_e = 1'b0; flush = 1'b0; op_d = 4'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_stall", {31'b0, md_stall}, 32'h0);
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    m_hi = '0; m_lo = '0; m_ph = '0; m_pl = '0; m_left = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(0, 20));
      4:       return -32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb, ns;
    logic [31:0] sav_hi, sav_lo;
    rst_n = 1'b0;
    op_e = 4'd0; valid_e = 1'b0; flush = 1'b0; a = '0; b = '0; op_d = 4'd0;
    m_hi = '0; m_lo = '0; m_ph = '0; m_pl = '0; m_left = 0;
    #12;
    chk("init_busy", {31'b0, busy}, 32'h0);
    chk("init_hi", hi, 32'h0);
    chk("init_lo", lo, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // mult -3 * 5
    step(4'd1, 1'b1, 1'b0, -32'd3, 32'd5, 4'd0);
    wait_free(4'd0, nb, ns);
    chk("mult_lat", nb, 5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFF1);

    step(4'd2, 1'b1, 1'b0, -32'd3, 32'd5, 4'd0);
    wait_free(4'd0, nb, ns);
    chk("multu_hi", hi, 32'h0000_0004);
    chk("multu_lo", lo, 32'hFFFF_FFF1);

    step(4'd3, 1'b1, 1'b0, -32'd7, 32'd2, 4'd0);
    wait_free(4'd0, nb, ns);
    chk("div_lat", nb, 10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    step(4'd4, 1'b1, 1'b0, 32'd7, 32'd0, 4'd0);
    wait_free(4'd0, nb, ns);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    chk("divu0_hi", hi, 32'd7);

    step(4'd3, 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 4'd0);
    wait_free(4'd0, nb, ns);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);

    // mthi then reads
    step(4'd7, 1'b1, 1'b0, 32'h1234, 32'h0, 4'd0);
    step(4'd6, 1'b1, 1'b0, 32'h0, 32'h0, 4'd0);
    chk("mthi_busy", {31'b0, obs_busy}, 32'h0);
    chk("mthi_hi", hi, 32'h1234);
    step(4'd5, 1'b1, 1'b0, 32'h0, 32'h0, 4'd0);
    chk("mfhi_rdata", obs_rdata, 32'h1234);

    // Stall with mflo in D
    step(4'd1, 1'b1, 1'b0, 32'd6, 32'd7, 4'd6);
    chk("stall_start", {31'b0, obs_stall}, 32'h1);
    wait_free(4'd6, nb, ns);
    chk("stall_cycles", ns, 5);
    chk("stall_drop", {31'b0, obs_stall}, 32'h0);

    // Flush blocks the start
    sav_hi = hi;
    sav_lo = lo;
    step(4'd1, 1'b1, 1'b1, 32'd9, 32'd9, 4'd0);
    idle(4'd0);
    chk("flush_busy", {31'b0, obs_busy}, 32'h0);
    #1;
    chk("flush_hi", hi, sav_hi);
    chk("flush_lo", lo, sav_lo);

    // Reset during busy cycle 3
    step(4'd1, 1'b1, 1'b0, 32'd7, 32'd9, 4'd0);
    idle(4'd0);
    idle(4'd0);
    apply_reset();
    for (int i = 0; i < 8; i++) idle(4'd0);
    #1;
    chk("postrst_hi", hi, 32'h0);
    chk("postrst_lo", lo, 32'h0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        apply_reset();
      end else begin
        step(4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 8),
             ($urandom_range(0, 9) < 1), pick_operand(), pick_operand(),
             4'($urandom_range(0, 15)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
